// File: rtl/gpu_vram_pkg.sv
// Shared VRAM map constants and types for background VRAM writers.
// VRAM_ADDR_WIDTH may be defined externally; it defaults to 12.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

package gpu_vram_pkg;
    localparam int ADDR_W = `VRAM_ADDR_WIDTH;

    typedef logic [ADDR_W-1:0] vram_addr_t;

    localparam vram_addr_t PMB_BASE  = vram_addr_t'(12'h200);
    localparam vram_addr_t NTBL_BASE = vram_addr_t'(12'h400);
    localparam vram_addr_t VRAM_END  = vram_addr_t'(12'h7FF);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, FIN} bg_dma_state_t;
endpackage

// File: rtl/vram_select_decode.sv
// Combinational VRAM address decode into the PMB / NTBL select lines.
module vram_select_decode
    import gpu_vram_pkg::*;
(
    input  vram_addr_t addr,
    output logic       sel_pmb,
    output logic       sel_ntbl
);
    assign sel_pmb  = (addr >= PMB_BASE)  && (addr < NTBL_BASE);
    assign sel_ntbl = (addr >= NTBL_BASE) && (addr <= VRAM_END);
endmodule

// File: rtl/background_dma.sv
// Background VRAM write-port sequencer: CPU writes pre-empt a block-fill engine.
// Define BACKGROUND_DMA_STRIDE32_EN to add the column input (address stride 32).
module background_dma
    import gpu_vram_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_data,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [7:0]        fill_value,
    input  logic              incr,
    input  logic              vblank_gate,
    input  logic              vblank,
`ifdef BACKGROUND_DMA_STRIDE32_EN
    input  logic              column,
`endif
    output logic [7:0]        data_in,
    output logic [ADDR_W-1:0] vram_address,
    output logic              write_enable,
    output logic              SELECT_pmb,
    output logic              SELECT_ntbl,
    output logic              busy,
    output logic              done,
    output logic              trunc
);
    bg_dma_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [7:0]        val_q, val_d;
    logic              incr_q, incr_d;
    logic              trunc_lat_q, trunc_lat_d;

    logic              eng_go, eng_last, eng_trunc, gated;
    logic [ADDR_W:0]   next_wide;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              dec_pmb, dec_ntbl;

    assign gated     = vblank_gate && !vblank;
    assign eng_go    = (state_q == RUN) && !abort && !cpu_we && !gated;
    assign eng_last  = (rem_q == LEN_W'(1));
    assign next_wide = {1'b0, addr_q} + {1'b0, stride_q};
    assign eng_trunc = next_wide > (ADDR_W+1)'(VRAM_END);

    // CPU always owns the port when it strobes; the engine simply holds.
    assign wr_en   = cpu_we || eng_go;
    assign wr_addr = cpu_we ? cpu_addr : addr_q;
    assign wr_data = cpu_we ? cpu_data : val_q;
    assign busy    = (state_q != IDLE);

    vram_select_decode u_decode (
        .addr     (wr_addr),
        .sel_pmb  (dec_pmb),
        .sel_ntbl (dec_ntbl)
    );

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start && !abort) state_d = (len == '0) ? FIN : ARMED;
            ARMED: begin
                if (abort)                       state_d = IDLE;
                else if (!vblank_gate || vblank) state_d = RUN;
            end
            RUN: begin
                if (abort)                                  state_d = IDLE;
                else if (gated)                             state_d = ARMED;
                else if (eng_go && (eng_last || eng_trunc)) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        stride_d    = stride_q;
        rem_d       = rem_q;
        val_d       = val_q;
        incr_d      = incr_q;
        trunc_lat_d = trunc_lat_q;
        if (state_q == IDLE && start && !abort) begin
            addr_d      = dst_addr;
            rem_d       = len;
            val_d       = fill_value;
            incr_d      = incr;
            trunc_lat_d = 1'b0;
`ifdef BACKGROUND_DMA_STRIDE32_EN
            stride_d    = column ? ADDR_W'(32) : ADDR_W'(1);
`else
            stride_d    = ADDR_W'(1);
`endif
        end else if (eng_go) begin
            addr_d      = addr_q + stride_q;
            rem_d       = rem_q - LEN_W'(1);
            val_d       = val_q + {7'b0, incr_q};
            // Running out of bytes on the final address is a full fill, not a truncation.
            trunc_lat_d = !eng_last && eng_trunc;
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            stride_q    <= '0;
            rem_q       <= '0;
            val_q       <= '0;
            incr_q      <= 1'b0;
            trunc_lat_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            rem_q       <= rem_d;
            val_q       <= val_d;
            incr_q      <= incr_d;
            trunc_lat_q <= trunc_lat_d;
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            write_enable <= 1'b0;
            vram_address <= '0;
            data_in      <= '0;
            SELECT_pmb   <= 1'b0;
            SELECT_ntbl  <= 1'b0;
            done         <= 1'b0;
            trunc        <= 1'b0;
        end else begin
            write_enable <= wr_en;
            vram_address <= wr_en ? wr_addr : '0;
            data_in      <= wr_en ? wr_data : '0;
            SELECT_pmb   <= wr_en && dec_pmb;
            SELECT_ntbl  <= wr_en && dec_ntbl;
            done         <= (state_q == FIN);
            trunc        <= (state_q == FIN) && trunc_lat_q;
        end
    end
endmodule

// File: tb/tb_background_dma.sv
// Randomized bench for background_dma against a per-fill write-list model.
`timescale 1ns/1ps
module tb_background_dma;
    logic        cpu_clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_data = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] dst_addr = '0;
    logic [10:0] len = '0;
    logic [7:0]  fill_value = '0;
    logic        incr = 1'b0;
    logic        vblank_gate = 1'b0;
    logic        vblank = 1'b0;
`ifdef BACKGROUND_DMA_STRIDE32_EN
    logic        column = 1'b0;
`endif
    logic [7:0]  data_in;
    logic [11:0] vram_address;
    logic        write_enable, SELECT_pmb, SELECT_ntbl, busy, done, trunc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc, first_wr_cyc, last_wr_cyc, done_cyc, eng_cnt;
    bit done_seen, expect_done, exp_trunc;
    logic [19:0] exp_q[$];
    logic [11:0] obs_log[$];

    background_dma dut (
        .cpu_clk      (cpu_clk),
        .rst          (rst),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .start        (start),
        .abort        (abort),
        .dst_addr     (dst_addr),
        .len          (len),
        .fill_value   (fill_value),
        .incr         (incr),
        .vblank_gate  (vblank_gate),
        .vblank       (vblank),
`ifdef BACKGROUND_DMA_STRIDE32_EN
        .column       (column),
`endif
        .data_in      (data_in),
        .vram_address (vram_address),
        .write_enable (write_enable),
        .SELECT_pmb   (SELECT_pmb),
        .SELECT_ntbl  (SELECT_ntbl),
        .busy         (busy),
        .done         (done),
        .trunc        (trunc)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_sel(input logic [11:0] a);
        return {(a >= 12'h200 && a <= 12'h3FF), (a >= 12'h400 && a <= 12'h7FF)};
    endfunction

    // Reference: byte i lands at dst+i*stride with value+i*incr until len or 0x7FF.
    task automatic model_fill(input logic [11:0] d, input int n, input logic [7:0] v,
                              input bit inc, input int stride);
        int a;
        logic [7:0] b;
        exp_q.delete();
        exp_trunc = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = int'(d) + i * stride;
            b = 8'(int'(v) + i * int'(inc));
            exp_q.push_back({a[11:0], b});
            if (i + 1 < n && a + stride > 'h7FF) begin
                exp_trunc = 1'b1;
                break;
            end
        end
        expect_done = 1'b1;
    endtask

    // One clock; outputs are examined 1ns after the edge against the inputs held across it.
    task automatic step();
        logic [19:0] e;
        @(posedge cpu_clk);
        #1;
        cyc++;
        if (cpu_we) begin
            check_eq("cpu_wr", {write_enable, SELECT_pmb, SELECT_ntbl, vram_address, data_in},
                     {1'b1, exp_sel(cpu_addr), cpu_addr, cpu_data});
            obs_log.push_back(vram_address);
        end else if (write_enable) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_wr", {63'b0, write_enable}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("eng_wr", {write_enable, SELECT_pmb, SELECT_ntbl, vram_address, data_in},
                         {1'b1, exp_sel(e[19:8]), e});
                if (eng_cnt == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                eng_cnt++;
                obs_log.push_back(vram_address);
            end
        end
        if (done) begin
            check_eq("done_expected", {63'b0, expect_done}, 64'd1);
            check_eq("trunc", {63'b0, trunc}, {63'b0, exp_trunc});
            check_eq("writes_left", exp_q.size(), 0);
            $display("fill start=%0d done=%0d writes=%0d trunc=%0b", start_cyc, cyc, eng_cnt, trunc);
            done_seen   = 1'b1;
            done_cyc    = cyc;
            expect_done = 1'b0;
        end
    endtask

    task automatic start_fill(input logic [11:0] d, input int n, input logic [7:0] v,
                              input bit inc, input bit col);
        int stride;
        stride = 1;
`ifdef BACKGROUND_DMA_STRIDE32_EN
        column = col;
        if (col) stride = 32;
`endif
        model_fill(d, n, v, inc, stride);
        done_seen = 1'b0;
        eng_cnt   = 0;
        obs_log.delete();
        dst_addr   = d;
        len        = 11'(n);
        fill_value = v;
        incr       = inc;
        start      = 1'b1;
        step();
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            if (rnd) begin
                cpu_we   = ($urandom_range(0, 3) == 0);
                cpu_addr = 12'($urandom);
                cpu_data = 8'($urandom);
                if (vblank_gate && $urandom_range(0, 3) == 0) vblank = !vblank;
            end
            step();
            n++;
        end
        cpu_we = 1'b0;
        if (!done_seen) check_eq("timeout", {63'b0, done_seen}, 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge cpu_clk);
        #1;
        check_eq("reset_outs", {write_enable, SELECT_pmb, SELECT_ntbl, vram_address, data_in, busy, done, trunc}, 0);
        @(negedge cpu_clk);
        rst = 1'b1;
        step();

        // NTBL fill with exact latency
        start_fill(12'h400, 4, 8'h21, 1'b1, 1'b0);
        wait_done(20, 1'b0);
        check_eq("ntbl_first_lat", first_wr_cyc - start_cyc, 2);
        check_eq("ntbl_span", last_wr_cyc - first_wr_cyc, 3);
        check_eq("ntbl_done_lat", done_cyc - last_wr_cyc, 1);
        check_eq("ntbl_busy_after", {63'b0, busy}, 64'd0);

        // CPU collision one cycle after the first engine write
        start_fill(12'h200, 3, 8'h55, 1'b0, 1'b0);
        for (int n = 0; n < 20 && eng_cnt < 1; n++) step();
        cpu_we = 1'b1; cpu_addr = 12'h610; cpu_data = 8'hAA;
        step();
        cpu_we = 1'b0;
        wait_done(20, 1'b0);
        check_eq("coll_count", obs_log.size(), 4);
        if (obs_log.size() == 4)
            check_eq("coll_order", {obs_log[0], obs_log[1], obs_log[2], obs_log[3]},
                     {12'h200, 12'h610, 12'h201, 12'h202});

        // Vblank gating and pause/resume
        vblank_gate = 1'b1; vblank = 1'b0;
        start_fill(12'h300, 2, 8'h80, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) step();
        check_eq("gate_busy", {63'b0, busy}, 64'd1);
        check_eq("gate_nowr", eng_cnt, 0);
        vblank = 1'b1;
        for (int n = 0; n < 20 && eng_cnt < 1; n++) step();
        vblank = 1'b0;
        for (int n = 0; n < 4; n++) step();
        check_eq("gate_pause", eng_cnt, 1);
        check_eq("gate_pause_busy", {63'b0, busy}, 64'd1);
        vblank = 1'b1;
        wait_done(20, 1'b0);
        check_eq("gate_total", eng_cnt, 2);
        vblank_gate = 1'b0; vblank = 1'b0;

        // Truncation at the top of NTBL
        start_fill(12'h7FE, 5, 8'h10, 1'b1, 1'b0);
        wait_done(20, 1'b0);
        check_eq("trunc_count", eng_cnt, 2);

        // Zero length
        start_fill(12'h300, 0, 8'h00, 1'b0, 1'b0);
        wait_done(10, 1'b0);
        check_eq("len0_lat", done_cyc - start_cyc, 1);
        check_eq("len0_writes", eng_cnt, 0);

        // Abort mid-RUN
        start_fill(12'h500, 20, 8'h01, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_busy", {63'b0, busy}, 64'd0);
        exp_q.delete();
        expect_done = 1'b0;
        for (int n = 0; n < 4; n++) step();
        check_eq("abort_writes", eng_cnt, 3);

        // Start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", {63'b0, busy}, 64'd0);
        for (int n = 0; n < 3; n++) step();

        // Asynchronous reset mid-fill
        start_fill(12'h600, 20, 8'h40, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) step();
        #2 rst = 1'b0;
        #1;
        check_eq("rst_outs", {write_enable, SELECT_pmb, SELECT_ntbl, vram_address, data_in, busy, done, trunc}, 0);
        exp_q.delete();
        expect_done = 1'b0;
        @(negedge cpu_clk);
        rst = 1'b1;
        for (int n = 0; n < 3; n++) step();

`ifdef BACKGROUND_DMA_STRIDE32_EN
        start_fill(12'h405, 3, 8'h07, 1'b0, 1'b1);
        wait_done(20, 1'b0);
        check_eq("col_writes", eng_cnt, 3);
        column = 1'b0;
`endif

        // Randomized fills with CPU traffic and vblank toggling
        for (int t = 0; t < 25; t++) begin
            bit col;
            col = 1'b0;
`ifdef BACKGROUND_DMA_STRIDE32_EN
            col = ($urandom_range(0, 2) == 0);
`endif
            vblank_gate = ($urandom_range(0, 1) == 1);
            vblank      = ($urandom_range(0, 1) == 1);
            start_fill(12'($urandom_range('h1F0, 'h7FF)), $urandom_range(0, 40),
                       8'($urandom), ($urandom_range(0, 1) == 1), col);
            wait_done(800, 1'b1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
